pe_mac_acc_array: RTL and testbench
===================================

PE_MAC_ACC_ARRAY -- requirements
Module: pe_mac_acc_array

Interface
REQ-001 SHALL have parameter NUM_TAPS, default 8, number of output taps (dot-product channels).
REQ-002 SHALL have parameter LANES, default 5, number of products summed per tap per beat.
REQ-003 SHALL have parameter DATA_W, default 8, width of each fmap and weight element.
REQ-004 SHALL have parameter ACC_W, default 24, width of each tap accumulator.
REQ-005 SHALL have parameter OUT_W, default 16, width of each output tap after requantisation.
REQ-006 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-007 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-008 SHALL have port in_valid  input  1  input beat valid.
REQ-009 SHALL have port in_ready  output  1  input beat accepted when in_valid && in_ready.
REQ-010 SHALL have port in_first  input  1  beat starts a new accumulation group.
REQ-011 SHALL have port in_last  input  1  beat ends the group; result is emitted after it.
REQ-012 SHALL have port fmap_data  input  NUM_TAPS*LANES*DATA_W  fmap elements; tap t, lane l at index (t*LANES+l)*DATA_W.
REQ-013 SHALL have port weight_data  input  NUM_TAPS*LANES*DATA_W  weight elements, same packing.
REQ-014 SHALL have port cfg_is_uint  input  1  0 signed operands/accumulation, 1 unsigned.
REQ-015 SHALL have port cfg_shift  input  5  requantisation right-shift amount (0..31).
REQ-016 SHALL have port out_valid  output  1  result valid.
REQ-017 SHALL have port out_ready  input  1  downstream accepts result.
REQ-018 SHALL have port out_data  output  NUM_TAPS*OUT_W  requantised taps, tap 0 in LSBs.
REQ-019 SHALL have port out_sat  output  NUM_TAPS  per-tap flag: accumulator or output saturated during the group.

Function
REQ-020 SHALL define stall = out_valid && !out_ready; in_ready SHALL equal !stall; every pipeline stage and the accumulators SHALL hold while stall is high.
REQ-021 SHALL be a 3-stage pipeline: S1 registers inputs and first/last; S2 registers LANES*NUM_TAPS products at full 2*DATA_W+1 width; S3 adds the per-tap lane sum into the accumulator.
REQ-022 A beat with last accepted at edge t SHALL produce out_valid high after edge t+3 when there is no stall; a stall adds one cycle per stalled cycle.
REQ-023 cfg_is_uint and cfg_shift SHALL be captured on acceptance of an in_first beat and held for the entire group; changes mid-group SHALL be ignored.
REQ-024 Operands SHALL be zero-extended when uint, sign-extended otherwise.
REQ-025 On a first beat, acc SHALL load the lane sum; otherwise acc SHALL become acc + lane sum, saturating to the ACC_W signed range (unsigned: 0..2^ACC_W-1), with the tap's sat bit set on clamp.
REQ-026 A beat carrying both first and last SHALL form a single-beat group.
REQ-027 After a last beat, accumulators SHALL be treated as zero, so a non-first beat following last starts a group from 0.
REQ-028 Output tap = (acc + round) >>> cfg_shift, with round = 2^(cfg_shift-1) when cfg_shift>0 else 0; the result SHALL be saturated to OUT_W (signed or unsigned per mode), setting sat on clamp.
REQ-029 out_data and out_sat SHALL remain stable while out_valid && !out_ready; out_valid SHALL drop after acceptance unless a new result completes in the same cycle.
REQ-030 in_valid low SHALL insert bubbles without disturbing accumulator contents.

Reset
REQ-031 While rst is high: in_ready=0, out_valid=0, out_data=0, out_sat=0, all stage valids, accumulators and captured config=0.
REQ-032 Reset mid-group SHALL discard the partial group; the first accepted beat after reset SHALL be treated as first regardless of in_first.

Structure
REQ-033 Shared package pe_mac_pkg SHALL hold the default parameter values and the saturation/round helper functions.
REQ-034 One sub-module, pe_tap_dot (LANES multipliers plus lane adder tree for one tap), SHALL be instantiated NUM_TAPS times.

Verification
REQ-035 Single-beat signed group, all fmap=3, weight=-2, shift=0 -> each tap out_data=-30 three cycles after acceptance, sat=0.
REQ-036 Four-beat unsigned group, fmap=255, weight=255, shift=4 -> acc=1300500, output clamped to 65535 with sat=1.
REQ-037 Two-beat group with out_ready held low 5 cycles after out_valid -> in_ready low, out_data stable, no beat lost.
REQ-038 cfg_shift=1, acc=3 -> output 2 (round half up); acc=-3 -> output -1.
REQ-039 rst asserted between beats 2 and 3 of a 4-beat group -> outputs zero; next beat (in_first=0) starts a fresh group.

Source files
------------

// File: rtl/pe_mac_pkg.sv
// pe_mac_pkg: default sizes and the saturation / rounding helpers
// shared by the MAC array. All helpers work on 64-bit signed values.
package pe_mac_pkg;

  localparam int NUM_TAPS_D = 8;
  localparam int LANES_D    = 5;
  localparam int DATA_W_D   = 8;
  localparam int ACC_W_D    = 24;
  localparam int OUT_W_D    = 16;

  typedef logic signed [63:0] wide_t;

  function automatic wide_t sat_max(input int w, input logic is_uint);
    sat_max = is_uint ? (wide_t'(1) <<< w) - wide_t'(1)
                      : (wide_t'(1) <<< (w - 1)) - wide_t'(1);
  endfunction

  function automatic wide_t sat_min(input int w, input logic is_uint);
    sat_min = is_uint ? wide_t'(0) : -(wide_t'(1) <<< (w - 1));
  endfunction

  function automatic logic sat_hit(input wide_t v, input int w,
                                   input logic is_uint);
    sat_hit = (v > sat_max(w, is_uint)) || (v < sat_min(w, is_uint));
  endfunction

  function automatic wide_t sat_clamp(input wide_t v, input int w,
                                      input logic is_uint);
    if (v > sat_max(w, is_uint))
      sat_clamp = sat_max(w, is_uint);
    else if (v < sat_min(w, is_uint))
      sat_clamp = sat_min(w, is_uint);
    else
      sat_clamp = v;
  endfunction

  // half-up rounding constant for a right shift of sh
  function automatic wide_t round_of(input logic [4:0] sh);
    round_of = (sh == 5'd0) ? wide_t'(0) : (wide_t'(1) <<< (sh - 5'd1));
  endfunction

endpackage

// File: rtl/pe_tap_dot.sv
// pe_tap_dot: one tap -- LANES multipliers registered as S2 products,
// then a lane adder giving lane_sum. Ports: clk, rst, en, is_uint, fmap, weight, lane_sum.
module pe_tap_dot
  import pe_mac_pkg::*;
#(
  parameter int LANES  = LANES_D,
  parameter int DATA_W = DATA_W_D
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      en,
  input  logic                                      is_uint,
  input  logic [LANES*DATA_W-1:0]                   fmap,
  input  logic [LANES*DATA_W-1:0]                   weight,
  output logic signed [2*DATA_W+$clog2(LANES):0]    lane_sum
);
  localparam int PW = 2 * DATA_W + 1;
  localparam int SW = PW + $clog2(LANES);

  logic signed [PW-1:0] a_x    [LANES];
  logic signed [PW-1:0] b_x    [LANES];
  logic signed [PW-1:0] prod_d [LANES];
  logic signed [PW-1:0] prod_q [LANES];

  // operands widened so one signed multiply covers both modes
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign a_x[l] = is_uint
      ? PW'({1'b0, fmap[l*DATA_W +: DATA_W]})
      : PW'($signed(fmap[l*DATA_W +: DATA_W]));
    assign b_x[l] = is_uint
      ? PW'({1'b0, weight[l*DATA_W +: DATA_W]})
      : PW'($signed(weight[l*DATA_W +: DATA_W]));
    assign prod_d[l] = a_x[l] * b_x[l];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int l = 0; l < LANES; l++) prod_q[l] <= '0;
    end else if (en) begin
      for (int l = 0; l < LANES; l++) prod_q[l] <= prod_d[l];
    end
  end

  always_comb begin
    lane_sum = '0;
    for (int l = 0; l < LANES; l++)
      lane_sum = lane_sum + SW'(prod_q[l]);
  end

endmodule

// File: rtl/pe_mac_acc_array.sv
// pe_mac_acc_array: NUM_TAPS dot-product accumulators, 3-stage pipe plus
// requantised output register. valid/ready in (first/last groups) and out.
module pe_mac_acc_array
  import pe_mac_pkg::*;
#(
  parameter int NUM_TAPS = NUM_TAPS_D,
  parameter int LANES    = LANES_D,
  parameter int DATA_W   = DATA_W_D,
  parameter int ACC_W    = ACC_W_D,
  parameter int OUT_W    = OUT_W_D
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic                             in_first,
  input  logic                             in_last,
  input  logic [NUM_TAPS*LANES*DATA_W-1:0] fmap_data,
  input  logic [NUM_TAPS*LANES*DATA_W-1:0] weight_data,
  input  logic                             cfg_is_uint,
  input  logic [4:0]                       cfg_shift,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [NUM_TAPS*OUT_W-1:0]        out_data,
  output logic [NUM_TAPS-1:0]              out_sat
);
  localparam int TW = LANES * DATA_W;
  localparam int FW = NUM_TAPS * TW;
  localparam int SW = 2 * DATA_W + 1 + $clog2(LANES);

  function automatic wide_t ext_acc(input logic [ACC_W-1:0] a,
                                    input logic u);
    ext_acc = u ? wide_t'(a) : wide_t'($signed(a));
  endfunction

  logic       stall, en, take;
  logic       fresh, first_eff;
  logic       grp_u, beat_u;
  logic [4:0] grp_sh, beat_sh;

  assign stall     = out_valid & ~out_ready;
  assign en        = ~stall;
  assign in_ready  = ~rst & ~stall;
  assign take      = in_valid & in_ready;
  // after reset or a last beat the next beat opens a group
  assign first_eff = in_first | fresh;
  assign beat_u    = first_eff ? cfg_is_uint : grp_u;
  assign beat_sh   = first_eff ? cfg_shift : grp_sh;

  always_ff @(posedge clk) begin
    if (rst) begin
      fresh  <= 1'b1;
      grp_u  <= 1'b0;
      grp_sh <= '0;
    end else if (take) begin
      fresh <= in_last;
      if (first_eff) begin
        grp_u  <= cfg_is_uint;
        grp_sh <= cfg_shift;
      end
    end
  end

  logic          s1_v, s1_first, s1_last, s1_u;
  logic [4:0]    s1_sh;
  logic [FW-1:0] s1_fmap, s1_wt;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v     <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      s1_u     <= 1'b0;
      s1_sh    <= '0;
      s1_fmap  <= '0;
      s1_wt    <= '0;
    end else if (en) begin
      s1_v     <= take;
      s1_first <= first_eff;
      s1_last  <= in_last;
      s1_u     <= beat_u;
      s1_sh    <= beat_sh;
      s1_fmap  <= fmap_data;
      s1_wt    <= weight_data;
    end
  end

  logic       s2_v, s2_first, s2_last, s2_u;
  logic [4:0] s2_sh;
  logic signed [SW-1:0] lane_sum [NUM_TAPS];

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_v     <= 1'b0;
      s2_first <= 1'b0;
      s2_last  <= 1'b0;
      s2_u     <= 1'b0;
      s2_sh    <= '0;
    end else if (en) begin
      s2_v     <= s1_v;
      s2_first <= s1_first;
      s2_last  <= s1_last;
      s2_u     <= s1_u;
      s2_sh    <= s1_sh;
    end
  end

  for (genvar t = 0; t < NUM_TAPS; t++) begin : g_tap
    pe_tap_dot #(
      .LANES  (LANES),
      .DATA_W (DATA_W)
    ) u_dot (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .is_uint  (s1_u),
      .fmap     (s1_fmap[t*TW +: TW]),
      .weight   (s1_wt[t*TW +: TW]),
      .lane_sum (lane_sum[t])
    );
  end

  logic [ACC_W-1:0]    acc_q [NUM_TAPS];
  logic [ACC_W-1:0]    acc_d [NUM_TAPS];
  wide_t               sum_w [NUM_TAPS];
  logic [NUM_TAPS-1:0] asat_q, asat_d;
  logic                s3_v, s3_last, s3_u;
  logic [4:0]          s3_sh;

  always_comb begin
    asat_d = '0;
    for (int t = 0; t < NUM_TAPS; t++) begin
      sum_w[t] = (s2_first ? wide_t'(0) : ext_acc(acc_q[t], s2_u))
               + wide_t'(lane_sum[t]);
      acc_d[t] = ACC_W'(sat_clamp(sum_w[t], ACC_W, s2_u));
      asat_d[t] = (~s2_first & asat_q[t])
                | sat_hit(sum_w[t], ACC_W, s2_u);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s3_v    <= 1'b0;
      s3_last <= 1'b0;
      s3_u    <= 1'b0;
      s3_sh   <= '0;
      asat_q  <= '0;
      for (int t = 0; t < NUM_TAPS; t++) acc_q[t] <= '0;
    end else if (en) begin
      s3_v    <= s2_v;
      s3_last <= s2_last;
      s3_u    <= s2_u;
      s3_sh   <= s2_sh;
      if (s2_v) begin
        asat_q <= asat_d;
        for (int t = 0; t < NUM_TAPS; t++) acc_q[t] <= acc_d[t];
      end
    end
  end

  wide_t                     rq_w [NUM_TAPS];
  logic [NUM_TAPS*OUT_W-1:0] od_d;
  logic [NUM_TAPS-1:0]       os_d;

  always_comb begin
    od_d = '0;
    os_d = '0;
    for (int t = 0; t < NUM_TAPS; t++) begin
      rq_w[t] = (ext_acc(acc_q[t], s3_u) + round_of(s3_sh)) >>> s3_sh;
      od_d[t*OUT_W +: OUT_W] = OUT_W'(sat_clamp(rq_w[t], OUT_W, s3_u));
      os_d[t] = asat_q[t] | sat_hit(rq_w[t], OUT_W, s3_u);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= '0;
    end else if (en) begin
      out_valid <= s3_v & s3_last;
      if (s3_v & s3_last) begin
        out_data <= od_d;
        out_sat  <= os_d;
      end
    end
  end

endmodule

// File: tb/tb_pe_mac_acc_array.sv
// tb_pe_mac_acc_array: random and directed groups against a
// group-level integer model; a monitor pops expected results.
module tb_pe_mac_acc_array;
  localparam int NT = 8;
  localparam int L  = 5;
  localparam int DW = 8;
  localparam int AW = 24;
  localparam int OW = 16;
  localparam int FW = NT * L * DW;

  typedef struct {
    logic [NT*OW-1:0] d;
    logic [NT-1:0]    s;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid, in_ready, in_first, in_last;
  logic [FW-1:0]    fmap_data, weight_data;
  logic             cfg_is_uint;
  logic [4:0]       cfg_shift;
  logic             out_valid, out_ready;
  logic [NT*OW-1:0] out_data;
  logic [NT-1:0]    out_sat;

  always #5 clk = ~clk;

  pe_mac_acc_array #(
    .NUM_TAPS (NT),
    .LANES    (L),
    .DATA_W   (DW),
    .ACC_W    (AW),
    .OUT_W    (OW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_first    (in_first),
    .in_last     (in_last),
    .fmap_data   (fmap_data),
    .weight_data (weight_data),
    .cfg_is_uint (cfg_is_uint),
    .cfg_shift   (cfg_shift),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_sat     (out_sat)
  );

  int     n_vec = 0;
  int     n_err = 0;
  exp_t   sb_q[$];
  bit     bp_en = 0;
  longint m_acc [NT];
  bit     m_sat [NT];
  bit     m_fresh = 1;
  bit     m_u = 0;
  int     m_sh = 0;

  task automatic check(input string nm, input logic [NT*OW-1:0] act,
                       input logic [NT*OW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask

  function automatic longint elem(input logic [DW-1:0] x, input bit u);
    return u ? longint'(x) : longint'($signed(x));
  endfunction

  function automatic longint clampl(input longint v, input int w,
                                    input bit u, output bit hit);
    longint hi = u ? (longint'(1) <<< w) - 1 : (longint'(1) <<< (w - 1)) - 1;
    longint lo = u ? 0 : -(longint'(1) <<< (w - 1));
    hit = (v > hi) || (v < lo);
    return (v > hi) ? hi : ((v < lo) ? lo : v);
  endfunction

  // group-level reference: dot products, saturating sum, requantise on last
  function automatic void model_beat(input bit f, input bit l, input bit u,
                                     input int sh, input logic [FW-1:0] fm,
                                     input logic [FW-1:0] wt);
    bit     fe = f || m_fresh;
    bit     hit;
    longint s, q;
    exp_t   e;
    if (fe) begin
      m_u  = u;
      m_sh = sh;
    end
    for (int t = 0; t < NT; t++) begin
      s = 0;
      for (int ln = 0; ln < L; ln++)
        s += elem(fm[(t*L+ln)*DW +: DW], m_u) * elem(wt[(t*L+ln)*DW +: DW], m_u);
      if (fe) begin
        m_acc[t] = 0;
        m_sat[t] = 0;
      end
      m_acc[t] = clampl(m_acc[t] + s, AW, m_u, hit);
      m_sat[t] = m_sat[t] | hit;
    end
    if (l) begin
      for (int t = 0; t < NT; t++) begin
        q = (m_acc[t] + ((m_sh > 0) ? (longint'(1) <<< (m_sh - 1)) : 0)) >>> m_sh;
        q = clampl(q, OW, m_u, hit);
        e.d[t*OW +: OW] = q[OW-1:0];
        e.s[t] = m_sat[t] | hit;
      end
      sb_q.push_back(e);
    end
    m_fresh = l;
  endfunction

  function automatic logic [FW-1:0] fill(input logic [DW-1:0] v);
    logic [FW-1:0] r;
    for (int i = 0; i < NT * L; i++) r[i*DW +: DW] = v;
    return r;
  endfunction

  function automatic logic [FW-1:0] rnd();
    logic [FW-1:0] r;
    for (int i = 0; i < FW; i++) r[i] = 1'($urandom);
    return r;
  endfunction

  // called at posedge+1; returns at posedge+1 after the accepting edge
  task automatic send_beat(input bit f, input bit l, input bit u, input int sh,
                           input logic [FW-1:0] fm, input logic [FW-1:0] wt);
    int c = 0;
    in_valid = 1'b1;
    in_first = f;
    in_last = l;
    cfg_is_uint = u;
    cfg_shift = 5'(sh);
    fmap_data = fm;
    weight_data = wt;
    @(negedge clk);
    while (!in_ready) begin
      c++;
      if (c > 200) begin
        n_vec++;
        n_err++;
        $display("FAIL send_timeout in_ready=%0b", in_ready);
        in_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    model_beat(f, l, u, sh, fm, wt);
  endtask

  task automatic drain();
    int c = 0;
    while (sb_q.size() != 0 && c < 300) begin
      @(posedge clk);
      c++;
    end
    if (sb_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout pending=%0d", sb_q.size());
      sb_q.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_output got=%h exp=none", out_data);
        end else begin
          e = sb_q.pop_front();
          check("out_data", out_data, e.d);
          check("out_sat", out_sat, e.s);
        end
      end
    end
  endtask

  task automatic bp_proc();
    forever begin
      @(posedge clk);
      #2;
      if (bp_en) out_ready = ($urandom_range(0, 3) != 0);
    end
  endtask

  initial begin
    logic [FW-1:0] fm, wt;
    int c, nb;
    rst = 1'b1;
    in_valid = 1'b0;
    in_first = 1'b0;
    in_last = 1'b0;
    fmap_data = '0;
    weight_data = '0;
    cfg_is_uint = 1'b0;
    cfg_shift = '0;
    out_ready = 1'b1;
    fork
      monitor();
      bp_proc();
    join_none

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_sat", out_sat, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // single-beat signed group: 5 lanes of 3*-2 -> -30, valid 3 edges later
    send_beat(1, 1, 0, 0, fill(8'd3), fill(8'hFE));
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("latency_out_valid", out_valid, (k == 3) ? 1 : 0);
    end
    drain();

    // four unsigned beats of 255*255, shift 4 -> clamp 65535
    for (int b = 0; b < 4; b++)
      send_beat(b == 0, b == 3, 1, 4, fill(8'hFF), fill(8'hFF));
    drain();

    // shift 1 rounding: even taps acc=3, odd taps acc=-3
    fm = '0;
    wt = '0;
    for (int t = 0; t < NT; t++) begin
      fm[t*L*DW +: DW] = (t % 2 == 0) ? 8'd3 : 8'hFD;
      wt[t*L*DW +: DW] = 8'd1;
    end
    send_beat(1, 1, 0, 1, fm, wt);
    drain();

    // unsigned accumulator saturation
    for (int b = 0; b < 60; b++)
      send_beat(b == 0, b == 59, 1, 0, fill(8'hFF), fill(8'hFF));
    drain();

    // signed negative accumulator saturation
    for (int b = 0; b < 110; b++)
      send_beat(b == 0, b == 109, 0, 8, fill(8'h80), fill(8'h7F));
    drain();

    // output stall: held data, in_ready low, queued beat not lost
    out_ready = 1'b0;
    send_beat(1, 0, 0, 2, rnd(), rnd());
    send_beat(0, 1, 1, 7, rnd(), rnd());
    c = 0;
    while (!out_valid && c < 20) begin
      @(negedge clk);
      c++;
    end
    check("stall_out_valid", out_valid, 1);
    @(posedge clk);
    #1;
    fork
      send_beat(1, 1, 1, 3, rnd(), rnd());
      begin
        repeat (5) begin
          @(negedge clk);
          check("stall_in_ready", in_ready, 0);
          if (sb_q.size() != 0) check("stall_out_data", out_data, sb_q[0].d);
        end
        @(posedge clk);
        #2;
        out_ready = 1'b1;
      end
    join
    drain();

    // reset between beats 2 and 3 discards the group
    send_beat(1, 0, 0, 0, rnd(), rnd());
    send_beat(0, 0, 0, 0, rnd(), rnd());
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_data", out_data, 0);
    check("midrst_out_sat", out_sat, 0);
    check("midrst_in_ready", in_ready, 0);
    m_fresh = 1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    send_beat(0, 1, 0, 1, rnd(), rnd());
    drain();

    // random groups, bubbles, backpressure, mid-group cfg noise
    bp_en = 1;
    for (int g = 0; g < 40; g++) begin
      nb = $urandom_range(1, 4);
      for (int b = 0; b < nb; b++) begin
        send_beat((b == 0) ? ($urandom_range(0, 4) != 0) : 1'b0,
                  b == nb - 1, 1'($urandom), $urandom_range(0, 12),
                  rnd(), rnd());
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
        end
      end
    end
    bp_en = 0;
    out_ready = 1'b1;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
